// File: rtl/vga_pkg.sv
// Shared definitions for the framebuffer producer (fb_writer) and the display
// side (vga). Both ends use the same pixel layout and word format.
//   DEFAULT_HDISP/DEFAULT_VDISP : default active frame size
//   DEFAULT_BURSTSIZE           : default words per Avalon write burst
//   BURSTCOUNT_W                : width of the Avalon burstcount field
//   rgb_t                       : {R, G, B}, 8 bits each
//   pattern_t                   : test pattern selector
//   pixel_to_word               : framebuffer word {8'h00, R, G, B}
package vga_pkg;

    localparam int unsigned DEFAULT_HDISP     = 800;
    localparam int unsigned DEFAULT_VDISP     = 480;
    localparam int unsigned DEFAULT_BURSTSIZE = 16;
    localparam int unsigned BURSTCOUNT_W      = 8;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        PatGrid     = 2'd0,
        PatBars     = 2'd1,
        PatSolid    = 2'd2,
        PatGradient = 2'd3
    } pattern_t;

    function automatic logic [31:0] pixel_to_word(input rgb_t rgb);
        return {8'h00, rgb};
    endfunction

endpackage

// File: rtl/avalon_if.sv
// Avalon-MM bundle between a burst-capable host and the SDRAM interconnect.
//   clk, reset  : interface-level clock/reset (not used by fb_writer)
//   address     : byte address of the first beat of a burst
//   write/read  : transfer requests
//   writedata   : 32-bit write word, byteenable : byte lanes
//   burstcount  : beats in the burst, waitrequest : agent back-pressure
interface avalon_if;

    logic                            clk;
    logic                            reset;
    logic [31:0]                     address;
    logic                            write;
    logic                            read;
    logic [31:0]                     writedata;
    logic [3:0]                      byteenable;
    logic [vga_pkg::BURSTCOUNT_W-1:0] burstcount;
    logic                            waitrequest;

    modport host (
        input  clk,
        input  reset,
        input  waitrequest,
        output address,
        output write,
        output read,
        output writedata,
        output byteenable,
        output burstcount
    );

    modport agent (
        input  clk,
        input  reset,
        output waitrequest,
        input  address,
        input  write,
        input  read,
        input  writedata,
        input  byteenable,
        input  burstcount
    );

endinterface

// File: rtl/fb_pattern.sv
// Combinational test-pattern generator: maps a pixel coordinate to a colour.
// Shared with the display-side self-test so both produce identical images.
//   x, y       : pixel coordinate (x < HDISP, y < VDISP)
//   pattern    : grid / colour bars / solid / gradient
//   solid_rgb  : colour used by the solid pattern
//   rgb        : resulting colour
// Requires HDISP >= 16 and VDISP >= 16 so the grid test can use the low nibble.
module fb_pattern
    import vga_pkg::*;
#(
    parameter int unsigned HDISP = DEFAULT_HDISP,
    parameter int unsigned VDISP = DEFAULT_VDISP,
    parameter int unsigned XW    = $clog2(HDISP),
    parameter int unsigned YW    = $clog2(VDISP)
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  pattern_t      pattern,
    input  rgb_t          solid_rgb,
    output rgb_t          rgb
);

    localparam int unsigned BAR_W = HDISP / 8;

    logic [XW-1:0] bar_full;
    logic [2:0]    bar;
    rgb_t          bar_rgb;

    always_comb begin
        bar_full = x / XW'(BAR_W);
        // When HDISP is not a multiple of 8 the last few columns fall past bar 7.
        bar      = (bar_full > XW'(7)) ? 3'd7 : bar_full[2:0];
        unique case (bar)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        rgb = '0;
        unique case (pattern)
            PatGrid:     rgb = (x[3:0] == 4'd0 || y[3:0] == 4'd0) ? 24'hFFFFFF : 24'h000000;
            PatBars:     rgb = bar_rgb;
            PatSolid:    rgb = solid_rgb;
            PatGradient: rgb = {8'(x), 8'(y), 8'h00};
            default:     rgb = '0;
        endcase
    end

endmodule

// File: rtl/fb_writer.sv
// Framebuffer writer: fills the SDRAM framebuffer with a generated test
// pattern in raster order using Avalon-MM write bursts of BURSTSIZE words.
//   sys_clk, sys_rst_n : system clock, synchronous active-low reset
//   start              : one-cycle frame request (ignored while busy)
//   continuous         : latched at start; restart after every frame
//   pattern, solid_rgb : latched at start; pattern select and solid colour
//   busy               : frame in progress
//   done               : one-cycle pulse in the gap after a frame's last beat
//   frame_count        : frames completed since reset (wraps)
//   avalon_ifh         : Avalon-MM host port (burst writes only)
module fb_writer
    import vga_pkg::*;
#(
    parameter int unsigned HDISP     = DEFAULT_HDISP,
    parameter int unsigned VDISP     = DEFAULT_VDISP,
    parameter int unsigned BURSTSIZE = DEFAULT_BURSTSIZE,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          start,
    input  logic          continuous,
    input  logic [1:0]    pattern,
    input  logic [23:0]   solid_rgb,
    output logic          busy,
    output logic          done,
    output logic [15:0]   frame_count,
    avalon_if.host        avalon_ifh
);

    localparam int unsigned XW          = $clog2(HDISP);
    localparam int unsigned YW          = $clog2(VDISP);
    localparam int unsigned BW          = $clog2(BURSTSIZE + 1);
    localparam logic [31:0] BURST_BYTES = 32'(4 * BURSTSIZE);
    localparam logic [31:0] LAST_ADDR   = BASE_ADDR + 32'(4 * HDISP * VDISP) - BURST_BYTES;

    typedef enum logic [1:0] {StIdle, StBurst, StGap} state_t;

    state_t                  state_q;
    logic [XW-1:0]           x_q;
    logic [YW-1:0]           y_q;
    logic [BW-1:0]           beat_q;
    logic [31:0]             addr_q;
    logic                    write_q;
    logic [31:0]             wdata_q;
    logic [BURSTCOUNT_W-1:0] bcount_q;
    logic                    busy_q;
    logic                    done_q;
    logic [15:0]             fcount_q;
    pattern_t                pat_q;
    rgb_t                    solid_q;
    logic                    cont_q;

    logic                    accept;
    logic                    x_last;
    logic                    y_last;
    logic                    beat_last;
    logic [XW-1:0]           x_nxt;
    logic [YW-1:0]           y_nxt;
    logic [XW-1:0]           pat_x;
    logic [YW-1:0]           pat_y;
    pattern_t                pat_sel;
    rgb_t                    pat_solid;
    rgb_t                    pat_rgb;

    always_comb begin
        accept    = write_q && !avalon_ifh.waitrequest;
        x_last    = (x_q == XW'(HDISP - 1));
        y_last    = (y_q == YW'(VDISP - 1));
        beat_last = (beat_q == BW'(BURSTSIZE - 1));
        x_nxt     = x_last ? '0 : x_q + XW'(1);
        y_nxt     = x_last ? (y_last ? '0 : y_q + YW'(1)) : y_q;
        // In IDLE the first word is built from the live inputs, since they are
        // only being latched on this edge; afterwards the latched copies are used
        // and the coordinate is the one that follows the beat being accepted.
        if (state_q == StIdle) begin
            pat_x     = x_q;
            pat_y     = y_q;
            pat_sel   = pattern_t'(pattern);
            pat_solid = rgb_t'(solid_rgb);
        end else begin
            pat_x     = x_nxt;
            pat_y     = y_nxt;
            pat_sel   = pat_q;
            pat_solid = solid_q;
        end
    end

    fb_pattern #(
        .HDISP (HDISP),
        .VDISP (VDISP)
    ) u_pattern (
        .x         (pat_x),
        .y         (pat_y),
        .pattern   (pat_sel),
        .solid_rgb (pat_solid),
        .rgb       (pat_rgb)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            beat_q   <= '0;
            addr_q   <= BASE_ADDR;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            bcount_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fcount_q <= '0;
            pat_q    <= PatGrid;
            solid_q  <= '0;
            cont_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        pat_q    <= pattern_t'(pattern);
                        solid_q  <= rgb_t'(solid_rgb);
                        cont_q   <= continuous;
                        addr_q   <= BASE_ADDR;
                        bcount_q <= BURSTCOUNT_W'(BURSTSIZE);
                        beat_q   <= '0;
                        wdata_q  <= pixel_to_word(pat_rgb);
                        write_q  <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= StBurst;
                    end
                end
                StBurst: begin
                    if (accept) begin
                        // x/y wrap to (0,0) after the frame's last pixel, so the
                        // next word is already the first one of the next frame.
                        x_q     <= x_nxt;
                        y_q     <= y_nxt;
                        wdata_q <= pixel_to_word(pat_rgb);
                        if (beat_last) begin
                            beat_q  <= '0;
                            write_q <= 1'b0;
                            state_q <= StGap;
                            if (addr_q == LAST_ADDR) begin
                                done_q   <= 1'b1;
                                fcount_q <= fcount_q + 16'd1;
                            end
                        end else begin
                            beat_q <= beat_q + BW'(1);
                        end
                    end
                end
                StGap: begin
                    // done_q is high exactly in the gap that closes a frame.
                    if (done_q) begin
                        addr_q <= BASE_ADDR;
                        if (cont_q) begin
                            write_q <= 1'b1;
                            state_q <= StBurst;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end
                    end else begin
                        addr_q  <= addr_q + BURST_BYTES;
                        write_q <= 1'b1;
                        state_q <= StBurst;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy                  = busy_q;
    assign done                  = done_q;
    assign frame_count           = fcount_q;
    assign avalon_ifh.address    = addr_q;
    assign avalon_ifh.write      = write_q;
    assign avalon_ifh.read       = 1'b0;
    assign avalon_ifh.writedata  = wdata_q;
    assign avalon_ifh.byteenable = 4'hF;
    assign avalon_ifh.burstcount = bcount_q;

endmodule

// File: tb/tb_fb_writer.sv
// Bench for fb_writer on a reduced 48x20 frame (960 pixels, 60 bursts of 16,
// 1020 cycles per unstalled frame) with BASE_ADDR = 0x1000.
module tb_fb_writer;
    import vga_pkg::*;

    localparam int          H        = 48;
    localparam int          V        = 20;
    localparam int          BS       = 16;
    localparam int          NPIX     = H * V;
    localparam int          FRAME_CY = (NPIX / BS) * (BS + 1);
    localparam logic [31:0] BASE     = 32'h0000_1000;
    localparam logic [31:0] LASTB    = BASE + 32'(4 * NPIX - 4 * BS);

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic [23:0] solid_rgb = 24'h0;
    logic        busy;
    logic        done;
    logic [15:0] frame_count;
    logic        waitreq = 1'b0;

    avalon_if av ();
    assign av.clk         = sys_clk;
    assign av.reset       = ~sys_rst_n;
    assign av.waitrequest = waitreq;

    fb_writer #(
        .HDISP     (H),
        .VDISP     (V),
        .BURSTSIZE (BS),
        .BASE_ADDR (BASE)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .start       (start),
        .continuous  (continuous),
        .pattern     (pattern),
        .solid_rgb   (solid_rgb),
        .busy        (busy),
        .done        (done),
        .frame_count (frame_count),
        .avalon_ifh  (av)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int failures = 0;
    bit stall_en = 1'b0;

    // memory model and bus observations
    logic [31:0] mem [NPIX];
    logic [31:0] ref_mem [NPIX];
    int          wcnt [NPIX];
    int          beats, bursts, beat_idx, dones, stall_cycles;
    int          bc_err, addr_err, range_err, be_err, rd_err, stab_err;
    logic [31:0] first_addr, last_burst_addr, burst_addr, prev_addr, prev_data;
    bit          prev_stall;

    typedef struct {
        logic [1:0]  pat;
        int          x;
        int          y;
        logic [31:0] exp;
    } spot_t;
    spot_t spots [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] pat, input logic [23:0] rgb,
                                          input int x, input int y);
        logic [23:0] c;
        int b;
        c = 24'h0;
        case (pat)
            2'd0: c = (x % 16 == 0 || y % 16 == 0) ? 24'hFFFFFF : 24'h000000;
            2'd1: begin
                b = x / (H / 8);
                if (b > 7) b = 7;
                case (b)
                    0: c = 24'hFFFFFF;
                    1: c = 24'hFFFF00;
                    2: c = 24'h00FFFF;
                    3: c = 24'h00FF00;
                    4: c = 24'hFF00FF;
                    5: c = 24'hFF0000;
                    6: c = 24'h0000FF;
                    default: c = 24'h000000;
                endcase
            end
            2'd2: c = rgb;
            default: c = 24'((x % 256) * 65536 + (y % 256) * 256);
        endcase
        return {8'h00, c};
    endfunction

    task automatic mon_clear();
        for (int i = 0; i < NPIX; i++) begin
            mem[i]  = 32'h0;
            wcnt[i] = 0;
        end
        beats = 0; bursts = 0; beat_idx = 0; dones = 0; stall_cycles = 0;
        bc_err = 0; addr_err = 0; range_err = 0; be_err = 0; rd_err = 0; stab_err = 0;
        first_addr = 32'hFFFF_FFFF; last_burst_addr = 32'hFFFF_FFFF;
        burst_addr = 32'h0; prev_stall = 1'b0;
    endtask

    // Observe the bus mid-cycle; a beat seen here is accepted at the next edge.
    task automatic sample();
        logic [31:0] off;
        int idx;
        if (!sys_rst_n) begin
            prev_stall = 1'b0;
            return;
        end
        if (done) dones++;
        if (av.read) rd_err++;
        if (av.write) begin
            if (av.byteenable != 4'hF) be_err++;
            if (prev_stall && (av.address != prev_addr || av.writedata != prev_data)) stab_err++;
            if (waitreq) begin
                stall_cycles++;
                prev_stall = 1'b1;
                prev_addr  = av.address;
                prev_data  = av.writedata;
            end else begin
                prev_stall = 1'b0;
                if (beat_idx == 0) begin
                    burst_addr = av.address;
                    if (bursts == 0) first_addr = av.address;
                    last_burst_addr = av.address;
                    bursts++;
                    if (av.burstcount != 8'(BS)) bc_err++;
                end else if (av.address != burst_addr) begin
                    addr_err++;
                end
                off = av.address - BASE;
                idx = int'(off >> 2) + beat_idx;
                if (off[1:0] != 2'b00 || off >= 32'(4 * NPIX) || idx >= NPIX) begin
                    range_err++;
                end else begin
                    mem[idx] = av.writedata;
                    wcnt[idx]++;
                end
                beat_idx = (beat_idx + 1) % BS;
                beats++;
            end
        end else begin
            prev_stall = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge sys_clk);
        #1;
        waitreq = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge sys_clk);
        sample();
    endtask

    task automatic start_frame(input logic [1:0] pat, input logic [23:0] rgb, input bit cont);
        pattern    = pat;
        solid_rgb  = rgb;
        continuous = cont;
        start      = 1'b1;
        cyc();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string name, input int n0, output int n);
        n = n0;
        while (!done && n < 4000) begin
            cyc();
            n++;
        end
        if (!done) chk({name, "_done_timeout"}, 32'(n), 32'(FRAME_CY));
    endtask

    task automatic check_frame(input string name, input logic [1:0] pat, input logic [23:0] rgb);
        int bad;
        bad = 0;
        for (int i = 0; i < NPIX; i++)
            if (wcnt[i] != 1 || mem[i] !== model(pat, rgb, i % H, i / H)) bad++;
        chk({name, "_bad_words"}, 32'(bad), 32'd0);
        chk({name, "_bus_errors"}, 32'(bc_err + addr_err + range_err + be_err + rd_err), 32'd0);
    endtask

    task automatic check_spots(input string name, input logic [1:0] pat);
        for (int i = 0; i < 14; i++)
            if (spots[i].pat == pat)
                chk($sformatf("%s_pix_%0d_%0d", name, spots[i].x, spots[i].y),
                    mem[spots[i].y * H + spots[i].x], spots[i].exp);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_frame_count"}, 32'(frame_count), 32'd0);
        chk({name, "_address"}, av.address, BASE);
        chk({name, "_write"}, 32'(av.write), 32'd0);
        chk({name, "_burstcount"}, 32'(av.burstcount), 32'd0);
        chk({name, "_writedata"}, av.writedata, 32'd0);
        chk({name, "_byteenable"}, 32'(av.byteenable), 32'hF);
    endtask

    initial begin
        int n;
        int diff;
        spots[0]  = '{2'd0, 0, 0, 32'h00FFFFFF};
        spots[1]  = '{2'd0, 1, 1, 32'h00000000};
        spots[2]  = '{2'd0, 16, 3, 32'h00FFFFFF};
        spots[3]  = '{2'd0, 47, 19, 32'h00000000};
        spots[4]  = '{2'd0, 5, 16, 32'h00FFFFFF};
        spots[5]  = '{2'd1, 6, 0, 32'h00FFFF00};
        spots[6]  = '{2'd1, 0, 5, 32'h00FFFFFF};
        spots[7]  = '{2'd1, 12, 0, 32'h0000FFFF};
        spots[8]  = '{2'd1, 20, 2, 32'h0000FF00};
        spots[9]  = '{2'd1, 41, 7, 32'h000000FF};
        spots[10] = '{2'd1, 47, 19, 32'h00000000};
        spots[11] = '{2'd3, 0, 0, 32'h00000000};
        spots[12] = '{2'd3, 30, 10, 32'h001E0A00};
        spots[13] = '{2'd3, 47, 19, 32'h002F1300};

        mon_clear();
        sys_rst_n = 1'b0;
        cyc();
        cyc();
        sys_rst_n = 1'b1;
        cyc();
        check_reset_outputs("reset");

        // Solid frame, no stalls
        mon_clear();
        start_frame(2'd2, 24'h123456, 1'b0);
        chk("a_first_write", 32'(av.write), 32'd1);
        chk("a_busy_rise", 32'(busy), 32'd1);
        wait_done("a", 1, n);
        chk("a_latency", 32'(n), 32'(FRAME_CY));
        chk("a_frame_count", 32'(frame_count), 32'd1);
        chk("a_busy_at_done", 32'(busy), 32'd1);
        chk("a_bursts", 32'(bursts), 32'(NPIX / BS));
        chk("a_first_addr", first_addr, BASE);
        chk("a_last_burst_addr", last_burst_addr, LASTB);
        check_frame("a", 2'd2, 24'h123456);
        cyc();
        chk("a_busy_fall", 32'(busy), 32'd0);
        chk("a_done_pulse_width", 32'(done), 32'd0);
        repeat (5) cyc();
        chk("a_done_count", 32'(dones), 32'd1);
        chk("a_idle_write", 32'(av.write), 32'd0);

        // Grid frame; a start coinciding with done is ignored
        mon_clear();
        start_frame(2'd0, 24'h0, 1'b0);
        wait_done("b", 1, n);
        chk("b_latency", 32'(n), 32'(FRAME_CY));
        pattern = 2'd1;
        start   = 1'b1;
        cyc();
        start   = 1'b0;
        chk("b_busy_fall", 32'(busy), 32'd0);
        repeat (3) cyc();
        chk("b_start_at_done_ignored", 32'(av.write | busy), 32'd0);
        chk("b_frame_count", 32'(frame_count), 32'd2);
        check_frame("b", 2'd0, 24'h0);
        check_spots("b", 2'd0);

        // Colour bars without stalls, kept as the reference image
        mon_clear();
        start_frame(2'd1, 24'h0, 1'b0);
        wait_done("c", 1, n);
        chk("c_latency", 32'(n), 32'(FRAME_CY));
        check_frame("c", 2'd1, 24'h0);
        check_spots("c", 2'd1);
        ref_mem = mem;
        repeat (2) cyc();

        // Colour bars with 50% random waitrequest
        mon_clear();
        stall_en = 1'b1;
        start_frame(2'd1, 24'h0, 1'b0);
        wait_done("d", 1, n);
        stall_en = 1'b0;
        chk("d_latency", 32'(n), 32'(FRAME_CY + stall_cycles));
        chk("d_stalls_seen", 32'(stall_cycles > 100), 32'd1);
        chk("d_stable_while_stalled", 32'(stab_err), 32'd0);
        diff = 0;
        for (int i = 0; i < NPIX; i++) if (mem[i] !== ref_mem[i]) diff++;
        chk("d_same_as_unstalled", 32'(diff), 32'd0);
        check_frame("d", 2'd1, 24'h0);
        chk("d_pix_yellow", mem[6], 32'h00FFFF00);
        chk("d_frame_count", 32'(frame_count), 32'd4);
        repeat (2) cyc();

        // Continuous mode; clearing continuous and a mid-frame start have no effect
        mon_clear();
        start_frame(2'd2, 24'hABCDEF, 1'b1);
        wait_done("e1", 1, n);
        chk("e1_latency", 32'(n), 32'(FRAME_CY));
        chk("e1_frame_count", 32'(frame_count), 32'd5);
        check_frame("e1", 2'd2, 24'hABCDEF);
        mon_clear();
        continuous = 1'b0;
        pattern    = 2'd0;
        cyc();
        chk("e1_restart_write", 32'(av.write), 32'd1);
        chk("e1_restart_addr", av.address, BASE);
        repeat (100) cyc();
        pattern = 2'd3;
        start   = 1'b1;
        cyc();
        start   = 1'b0;
        wait_done("e2", 102, n);
        chk("e2_period", 32'(n), 32'(FRAME_CY));
        chk("e2_frame_count", 32'(frame_count), 32'd6);
        check_frame("e2", 2'd2, 24'hABCDEF);
        mon_clear();
        cyc();
        chk("e2_still_continuous", 32'(av.write), 32'd1);
        chk("e2_restart_addr", av.address, BASE);

        // Reset while beat 7 of the burst is presented
        n = 0;
        while (beats < 8 && n < 100) begin
            cyc();
            n++;
        end
        chk("r_reached_beat7", 32'(beats), 32'd8);
        sys_rst_n = 1'b0;
        cyc();
        sys_rst_n = 1'b1;
        check_reset_outputs("r");
        repeat (3) cyc();
        chk("r_stays_idle", 32'(av.write | busy), 32'd0);

        // Fresh gradient frame after reset
        mon_clear();
        start_frame(2'd3, 24'h0, 1'b0);
        chk("f_first_addr", av.address, BASE);
        wait_done("f", 1, n);
        chk("f_latency", 32'(n), 32'(FRAME_CY));
        chk("f_frame_count", 32'(frame_count), 32'd1);
        chk("f_bursts", 32'(bursts), 32'(NPIX / BS));
        chk("f_first_burst", first_addr, BASE);
        check_frame("f", 2'd3, 24'h0);
        check_spots("f", 2'd3);
        repeat (2) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_writer.md
# fb_writer

Framebuffer writer: Avalon-MM burst-write host that fills the SDRAM framebuffer with a generated test pattern, one 32-bit word per pixel, in raster order. It is the producer side of the framebuffer that the `vga` display controller scans out, and it uses the same address map:

- pixel (x,y) lives at byte address BASE_ADDR + 4·(y·HDISP + x);
- the data word is {8'h00, R, G, B}.

It sits on the system (Avalon) clock domain.

## Interface
Parameters:
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- BURSTSIZE, 16, words per write burst; HDISP·VDISP must be a multiple of BURSTSIZE
- BASE_ADDR, 0, byte address of pixel (0,0); 64-byte aligned

Ports:
- sys_clk  in  1  system clock; the Avalon interface is synchronous to it
- sys_rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to write one frame; ignored while busy
- continuous  in  1  sampled at start; 1 = restart automatically after each frame
- pattern  in  2  sampled at start:
  - 0 = grid
  - 1 = colour bars
  - 2 = solid
  - 3 = gradient
- solid_rgb  in  24  colour for pattern 2, sampled at start
- busy  out  1  high from the cycle after an accepted start until the frame completes
- done  out  1  one-cycle pulse after the last word of each frame is accepted
- frame_count  out  16  frames completed since reset, wraps
- avalon_ifh  avalon_if.host  —  uses the following fields; the interface's own clk and reset fields are not used:
  - address (32)
  - write
  - writedata (32)
  - byteenable (4)
  - burstcount
  - waitrequest
  - read: tied 0

## Operation
- Reset state and outputs:
  - state IDLE, x = y = 0
  - busy = 0, done = 0, frame_count = 0
  - address = BASE_ADDR, write = 0, burstcount = 0, writedata = 0
  - byteenable = 4'hF at all times
- States:
  - IDLE: on start=1, latch pattern, solid_rgb and continuous; load burstcount = BURSTSIZE and address of the current burst; assert write with the first word; go to BURST.
  - BURST: write held high. A beat is accepted on any cycle with write=1 and waitrequest=0. On acceptance:
    - beat counter +1;
    - x advances, wrapping to 0 at HDISP with y+1;
    - writedata presents the next pixel.
    - After the BURSTSIZE-th accepted beat: deassert write, go to GAP.
  - GAP: one cycle with write=0.
    - Address += 4·BURSTSIZE.
    - If the frame is not complete: reassert write, go to BURST.
    - Otherwise: pulse done, frame_count +1, reset x, y and address. Go to BURST if continuous was latched high, else IDLE with busy=0.
- Address, burstcount and writedata change only on acceptance or in IDLE/GAP. Writedata is never changed while write=1 and waitrequest=1.
- Patterns, computed from the (x,y) of the beat being presented:
  - grid: white if x%16==0 or y%16==0, else black
  - colour bars: 8 bars of width HDISP/8, in the order white, yellow, cyan, green, magenta, red, blue, black
  - solid: the latched solid_rgb
  - gradient: {x[7:0], y[7:0], 8'h00}
- Width rules:
  - x is $clog2(HDISP) bits, y is $clog2(VDISP) bits.
  - The address adder is 32 bits; its highest value is BASE_ADDR + 4·HDISP·VDISP − 4·BURSTSIZE.
- Boundary conditions:
  - start while busy: ignored.
  - start coinciding with the done pulse: ignored.
  - Reset mid-burst: the next edge with sys_rst_n=0 drops write and returns to IDLE, leaving a partial burst; the interconnect is reset together with this block.
  - Clearing continuous mid-frame has no effect until a new start.

## Timing
- With waitrequest=0 throughout, each burst takes BURSTSIZE+1 cycles (BURSTSIZE beats plus GAP).
- One frame takes (HDISP·VDISP/BURSTSIZE)·(BURSTSIZE+1) cycles, i.e. 408 000 cycles at the defaults.
- First beat: write is high in the cycle after start is sampled. busy rises in the same cycle.
- done: asserted for the single GAP cycle that follows the final accepted beat. In single-shot mode busy falls one cycle later.
- Each waitrequest=1 cycle stalls the block by exactly one cycle; no beat is lost or duplicated.

## Structure
- Shared package vga_pkg:
  - default HDISP and VDISP
  - rgb_t (24-bit {R,G,B})
  - pattern_t enum (GRID, BARS, SOLID, GRADIENT)
  - BURSTSIZE
  - pixel_to_word function {8'h00, rgb}

  The display controller uses the same package so both ends agree on layout.
- State enum (IDLE, BURST, GAP) is local to the module.
- One sub-module: fb_pattern. Purely combinational; maps (x, y, pattern, solid_rgb) to rgb_t. It is reused by the display-side self-test.

## Test plan
- Reset, then start with pattern=2, solid_rgb=24'h123456, waitrequest=0:
  - 24 000 bursts are written, each with burstcount=16;
  - first address = 0, last burst address = 0x176FC0;
  - every word = 32'h00123456;
  - done pulses once, frame_count=1, busy=0.
- Grid pattern, single shot:
  - memory model word (0,0) = 0x00FFFFFF, (1,1) = 0x00000000, (16,3) = 0x00FFFFFF, (799,479) = 0x00000000.
- Random waitrequest (50%) during a colour-bar frame:
  - memory contents are identical to the no-stall run;
  - writedata and address stay stable while stalled;
  - the word at x=100 is yellow, 0x00FFFF00.
- continuous=1: frame_count increments every 408 000 cycles; the address wraps to BASE_ADDR after each done. A start issued during the frame is ignored.
- sys_rst_n low for one cycle mid-burst (beat 7): write=0 on the next edge and all outputs return to reset values. A fresh start then restarts at address BASE_ADDR.
- Gradient pattern with BASE_ADDR=0x1000:
  - first word at 0x1000;
  - pixel (300,200) at 0x1000 + 4·(200·800+300), value 0x002CC800.
